// File: rtl/sram_rw_port_ctrl.sv
// Valid/ready front end for one read-write port of a *_ext SRAM macro, with an in-order response FIFO.
// Optional feature: define SRAM_CTRL_WRITE_ACK_EN to return an in-order ack for every accepted write.
module sram_rw_port_ctrl #(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 352,
    parameter int MASK_W     = 16,
    parameter int RESP_DEPTH = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [MASK_W-1:0] req_wmask,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_is_write,
    output logic              RW0_en,
    output logic              RW0_wmode,
    output logic [ADDR_W-1:0] RW0_addr,
    output logic [MASK_W-1:0] RW0_wmask,
    output logic [DATA_W-1:0] RW0_wdata,
    input  logic [DATA_W-1:0] RW0_rdata
);
    localparam int CNT_W = $clog2(RESP_DEPTH + 1);
    localparam int PTR_W = $clog2(RESP_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RESP_DEPTH - 1);

    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic             inflight_q, inflight_d;
    logic [CNT_W:0]   credit_used;
    logic             fire, produce, enq, deq;
    logic [DATA_W-1:0] enq_rdata;
    logic [DATA_W-1:0] rdata_mem [RESP_DEPTH];

    // A read in flight already owns a FIFO slot, so it is counted against the credit.
    assign credit_used = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    assign req_ready   = !reset && (credit_used < (CNT_W+1)'(RESP_DEPTH));
    assign fire        = req_valid && req_ready;

    assign RW0_en    = fire;
    assign RW0_wmode = req_write;
    assign RW0_addr  = req_addr;
    assign RW0_wmask = req_wmask;
    assign RW0_wdata = req_wdata;

    assign enq        = inflight_q;
    assign resp_valid = (count_q != '0);
    assign deq        = resp_valid && resp_ready;
    assign resp_rdata = rdata_mem[rptr_q];

`ifdef SRAM_CTRL_WRITE_ACK_EN
    logic inflight_wr_q, inflight_wr_d;
    logic wr_mem [RESP_DEPTH];

    assign produce       = fire;
    assign inflight_wr_d = fire && req_write;
    assign enq_rdata     = inflight_wr_q ? '0 : RW0_rdata;
    assign resp_is_write = wr_mem[rptr_q];

    always_ff @(posedge clock) begin
        if (reset) begin
            inflight_wr_q <= 1'b0;
        end else begin
            inflight_wr_q <= inflight_wr_d;
        end
        if (enq) begin
            wr_mem[wptr_q] <= inflight_wr_q;
        end
    end
`else
    assign produce       = fire && !req_write;
    assign enq_rdata     = RW0_rdata;
    assign resp_is_write = 1'b0;
`endif

    always_comb begin
        inflight_d = produce;
        count_d    = count_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        if (enq) begin
            wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + PTR_W'(1);
        end
        if (deq) begin
            rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + PTR_W'(1);
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            inflight_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            inflight_q <= inflight_d;
        end
    end

    // Payload storage needs no reset; entries are only visible once count says so.
    always_ff @(posedge clock) begin
        if (enq) begin
            rdata_mem[wptr_q] <= enq_rdata;
        end
    end

endmodule
